// File: rtl/sprite_compositor_if.sv
// Sprite compositor bus: per-pixel layer colours and frame controls in, composited pixel and
// collision status out.
//   pix_valid     pixel is in the active area
//   frame_start   one-cycle pulse on the first pixel slot of a frame
//   layer_color   layer i at bits [i*COLOR_W +: COLOR_W], layer 0 on top
//   layer_en_cfg  requested layer enables, taken at frame_start only
//   color         composited pixel colour
//   color_valid   pix_valid delayed by two clocks
//   collide       per-layer overlap flags from the previous frame
//   collide_irq   one-cycle pulse when collide is reloaded with a nonzero value
// master = pixel source, slave = compositor.
interface sprite_compositor_if #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned COLOR_W    = 8
);
  logic                          pix_valid;
  logic                          frame_start;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic [NUM_LAYERS-1:0]         layer_en_cfg;
  logic [COLOR_W-1:0]            color;
  logic                          color_valid;
  logic [NUM_LAYERS-1:0]         collide;
  logic                          collide_irq;

  modport master (
    output pix_valid, frame_start, layer_color, layer_en_cfg,
    input  color, color_valid, collide, collide_irq
  );

  modport slave (
    input  pix_valid, frame_start, layer_color, layer_en_cfg,
    output color, color_valid, collide, collide_irq
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage priority compositor for the pacman video path. Layer 0 has the highest priority;
// a layer whose colour equals KEY_COLOR is transparent. Layer enables are frame-synchronous.
// Overlaps between REF_LAYER (pacman) and any other opaque layer are accumulated over a frame
// and published at the next frame_start.
//   clk  pixel clock
//   rst  synchronous reset, active-low
//   bus  sprite_compositor_if slave modport (pixel stream in, colour/collision out)
module sprite_compositor #(
  parameter int unsigned         NUM_LAYERS = 6,
  parameter int unsigned         COLOR_W    = 8,
  parameter logic [COLOR_W-1:0]  KEY_COLOR  = '0,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = '0,
  parameter int unsigned         REF_LAYER  = 4
) (
  input logic                 clk,
  input logic                 rst,
  sprite_compositor_if.slave  bus
);

  logic [NUM_LAYERS-1:0]         en_active_q;
  logic [NUM_LAYERS-1:0]         en_use;
  logic [NUM_LAYERS-1:0]         opq;

  // Stage 1
  logic [NUM_LAYERS*COLOR_W-1:0] colors_q;
  logic [NUM_LAYERS-1:0]         opq_q;
  logic                          valid_q;
  logic                          fs_q;
  logic [NUM_LAYERS-1:0]         hit_oth;
  logic [NUM_LAYERS-1:0]         hit;

  // Stage 2
  logic [COLOR_W-1:0]            pick;
  logic [COLOR_W-1:0]            color_q;
  logic                          color_valid_q;
  logic [NUM_LAYERS-1:0]         acc_q;
  logic [NUM_LAYERS-1:0]         collide_q;
  logic                          irq_q;

  // The frame_start pixel already sees the new enables.
  always_comb begin
    en_use = bus.frame_start ? bus.layer_en_cfg : en_active_q;
    opq    = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      opq[i] = en_use[i] && (bus.layer_color[i*COLOR_W +: COLOR_W] != KEY_COLOR);
    end
  end

  // The reference layer is flagged whenever any other layer overlapped it.
  always_comb begin
    hit_oth = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (i != REF_LAYER) begin
        hit_oth[i] = opq_q[i] && opq_q[REF_LAYER] && valid_q;
      end
    end
    hit            = hit_oth;
    hit[REF_LAYER] = |hit_oth;
  end

  always_comb begin
    logic found;
    pick  = BG_COLOR;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (opq_q[i] && !found) begin
        pick  = colors_q[i*COLOR_W +: COLOR_W];
        found = 1'b1;
      end
    end
    if (!valid_q) begin
      pick = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_active_q   <= '1;
      colors_q      <= '0;
      opq_q         <= '0;
      valid_q       <= 1'b0;
      fs_q          <= 1'b0;
      color_q       <= BG_COLOR;
      color_valid_q <= 1'b0;
      acc_q         <= '0;
      collide_q     <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        en_active_q <= bus.layer_en_cfg;
      end
      colors_q      <= bus.layer_color;
      opq_q         <= opq;
      valid_q       <= bus.pix_valid;
      fs_q          <= bus.frame_start;
      color_q       <= pick;
      color_valid_q <= valid_q;
      // The frame_start pixel belongs to the new frame: it seeds acc, not the publish.
      if (fs_q) begin
        collide_q <= acc_q;
        acc_q     <= hit;
        irq_q     <= |acc_q;
      end else begin
        acc_q     <= acc_q | hit;
        irq_q     <= 1'b0;
      end
    end
  end

  assign bus.color       = color_q;
  assign bus.color_valid = color_valid_q;
  assign bus.collide     = collide_q;
  assign bus.collide_irq = irq_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int unsigned NL  = 6;
  localparam int unsigned CW  = 8;
  localparam int unsigned REF = 4;
  localparam logic [7:0]  BG  = 8'h00;
  localparam logic [5:0]  ALL = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  sprite_compositor #(
    .NUM_LAYERS(NL), .COLOR_W(CW), .KEY_COLOR(8'h00), .BG_COLOR(BG), .REF_LAYER(REF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [5:0] m_en_act, m_acc, m_collide;
  logic       m_irq;
  logic [7:0] p_color;
  logic       p_valid, p_fs;
  logic [5:0] p_hit;
  logic [7:0] exp_color;
  logic       exp_valid, exp_irq;
  logic [5:0] exp_collide;

  function automatic logic [47:0] pack(input logic [7:0] l0, l1, l2, l3, l4, l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic drive(input logic v, input logic fs, input logic [47:0] lc,
                       input logic [5:0] cfg);
    bus.pix_valid    = v;
    bus.frame_start  = fs;
    bus.layer_color  = lc;
    bus.layer_en_cfg = cfg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 48'h0, ALL);
  endtask

  // Clocks one pixel through; expectations reflect the pixel presented one step earlier.
  task automatic step();
    logic [5:0] en_use, opq, hit;
    logic [7:0] c;
    logic       v, fs;
    v      = bus.pix_valid;
    fs     = bus.frame_start;
    en_use = fs ? bus.layer_en_cfg : m_en_act;
    if (fs) m_en_act = bus.layer_en_cfg;
    for (int i = 0; i < 6; i++) opq[i] = en_use[i] && (bus.layer_color[i*8 +: 8] != 8'h00);
    c = BG;
    for (int i = 5; i >= 0; i--) if (opq[i]) c = bus.layer_color[i*8 +: 8];
    if (!v) c = BG;
    hit = '0;
    if (v && opq[REF]) begin
      hit      = opq;
      hit[REF] = 1'b0;
      hit[REF] = (hit != 0);
    end
    @(posedge clk);
    #1;
    if (p_fs) begin
      m_collide = m_acc;
      m_acc     = p_hit;
      m_irq     = (m_collide != 0);
    end else begin
      m_acc = m_acc | p_hit;
      m_irq = 1'b0;
    end
    exp_color   = p_color;
    exp_valid   = p_valid;
    exp_collide = m_collide;
    exp_irq     = m_irq;
    p_color = c;
    p_valid = v;
    p_fs    = fs;
    p_hit   = hit;
  endtask

  task automatic rst_step();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_en_act = ALL; m_acc = '0; m_collide = '0; m_irq = 1'b0;
    p_color = BG; p_valid = 1'b0; p_fs = 1'b0; p_hit = '0;
    exp_color = BG; exp_valid = 1'b0; exp_collide = '0; exp_irq = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_step();
    rst_step();
    n_vec++;
    if ({bus.color, bus.color_valid, bus.collide, bus.collide_irq} !== {8'h00, 1'b0, 6'h0, 1'b0})
    begin
      n_err++;
      $display("FAIL reset: got color=%h valid=%b collide=%b irq=%b want 00/0/000000/0",
               bus.color, bus.color_valid, bus.collide, bus.collide_irq);
    end
  endtask

  task automatic test_priority();
    drive(1, 0, pack(8'h00, 8'hE3, 8'h00, 8'h00, 8'hFC, 8'h03), ALL); step();
    drive(1, 0, pack(8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h03), ALL); step();
    n_vec++;
    if ({bus.color, bus.color_valid} !== {8'hE3, 1'b1}) begin
      n_err++;
      $display("FAIL priority_l1: got %h/%b want e3/1", bus.color, bus.color_valid);
    end
    idle(); step();
    n_vec++;
    if ({bus.color, bus.color_valid} !== {8'h1C, 1'b1}) begin
      n_err++;
      $display("FAIL priority_l2: got %h/%b want 1c/1", bus.color, bus.color_valid);
    end
  endtask

  task automatic test_transparency();
    drive(1, 0, 48'h0, ALL); step();
    drive(1, 0, pack(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03), ALL); step();
    n_vec++;
    if ({bus.color, bus.color_valid} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL all_transparent: got %h/%b want 00/1", bus.color, bus.color_valid);
    end
    drive(0, 0, pack(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03), ALL); step();
    n_vec++;
    if ({bus.color, bus.color_valid} !== {8'h03, 1'b1}) begin
      n_err++;
      $display("FAIL bottom_layer: got %h/%b want 03/1", bus.color, bus.color_valid);
    end
    idle(); step();
    n_vec++;
    if ({bus.color, bus.color_valid} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL blanking: got %h/%b want 00/0", bus.color, bus.color_valid);
    end
  endtask

  task automatic test_enable_shadow();
    logic [47:0] lc;
    lc = pack(8'hE0, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1, 0, lc, 6'b111110); step();
    drive(1, 1, lc, 6'b111110); step();
    n_vec++;
    if (bus.color !== 8'hE0) begin
      n_err++;
      $display("FAIL en_midframe: got %h want e0", bus.color);
    end
    drive(1, 0, lc, ALL); step();
    n_vec++;
    if (bus.color !== 8'hEF) begin
      n_err++;
      $display("FAIL en_at_frame_start: got %h want ef", bus.color);
    end
    idle(); step();
    n_vec++;
    if (bus.color !== 8'hEF) begin
      n_err++;
      $display("FAIL en_held: got %h want ef", bus.color);
    end
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
  endtask

  task automatic test_collision();
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    drive(1, 0, pack(8'h00, 8'h00, 8'h1F, 8'h00, 8'hFC, 8'h00), ALL); step();
    drive(1, 0, pack(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), ALL); step();
    n_vec++;
    if (bus.color !== 8'h1F) begin
      n_err++;
      $display("FAIL overlap_color: got %h want 1f", bus.color);
    end
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b010100, 1'b1}) begin
      n_err++;
      $display("FAIL collide_publish: got %b/%b want 010100/1", bus.collide, bus.collide_irq);
    end
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b010100, 1'b0}) begin
      n_err++;
      $display("FAIL irq_one_cycle: got %b/%b want 010100/0", bus.collide, bus.collide_irq);
    end
    idle(); step();
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b000000, 1'b0}) begin
      n_err++;
      $display("FAIL collide_clear: got %b/%b want 000000/0", bus.collide, bus.collide_irq);
    end
  endtask

  task automatic test_boundary();
    drive(1, 1, pack(8'h00, 8'h00, 8'h1F, 8'h00, 8'hFC, 8'h00), ALL); step();
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b000000, 1'b0}) begin
      n_err++;
      $display("FAIL fs_pixel_excluded: got %b/%b want 000000/0", bus.collide, bus.collide_irq);
    end
    idle(); step();
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b010100, 1'b1}) begin
      n_err++;
      $display("FAIL fs_pixel_next: got %b/%b want 010100/1", bus.collide, bus.collide_irq);
    end
    drive(1, 1, pack(8'h00, 8'h00, 8'h00, 8'h3C, 8'hFC, 8'h00), ALL); step();
    drive(0, 1, 48'h0, ALL); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b000000, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_first: got %b/%b want 000000/0", bus.collide, bus.collide_irq);
    end
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b011000, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_second: got %b/%b want 011000/1", bus.collide, bus.collide_irq);
    end
    idle(); step();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    drive(1, 0, pack(8'h00, 8'h00, 8'h1F, 8'h00, 8'hFC, 8'h00), ALL); step();
    idle(); step();
    rst_step();
    n_vec++;
    if ({bus.color, bus.color_valid, bus.collide, bus.collide_irq} !== {8'h00, 1'b0, 6'h0, 1'b0})
    begin
      n_err++;
      $display("FAIL reset_mid: got %h/%b/%b/%b want 00/0/000000/0",
               bus.color, bus.color_valid, bus.collide, bus.collide_irq);
    end
    drive(0, 1, 48'h0, ALL); step();
    idle(); step();
    n_vec++;
    if ({bus.collide, bus.collide_irq} !== {6'b000000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_discard: got %b/%b want 000000/0", bus.collide, bus.collide_irq);
    end
  endtask

  task automatic test_random();
    logic [47:0] lc;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 6; i++) lc[i*8 +: 8] = ($urandom_range(0, 2) != 0) ? 8'($urandom) : 8'h00;
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), lc,
            ($urandom_range(0, 2) == 0) ? 6'($urandom) : ALL);
      if ($urandom_range(0, 149) == 0) rst_step();
      else step();
      n_vec++;
      if ({bus.color, bus.color_valid, bus.collide, bus.collide_irq} !==
          {exp_color, exp_valid, exp_collide, exp_irq}) begin
        n_err++;
        $display("FAIL random[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", n,
                 bus.color, bus.color_valid, bus.collide, bus.collide_irq,
                 exp_color, exp_valid, exp_collide, exp_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_transparency();
    test_enable_shadow();
    test_collision();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
